fp_div: RTL and testbench
=========================

Name: fp_div

Overview:
- Sequential floating-point divider. It is the inverse-operation companion to the team's combinational FP multiplier and uses the same packed format: {sign, (INT_W-1)-bit biased exponent, FRAC_W-bit fraction}, bias 127.
- Computes quotient = i_data_a / i_data_b with restoring division, one quotient bit per cycle, then rounds to nearest even.
- Sits in the ALU datapath beside the multiplier. Accepts one operation at a time through a valid/busy handshake.

Parameters:
- INT_W, 9, sign bit plus exponent bits (exponent width = INT_W-1).
- FRAC_W, 23, stored fraction width.
- DATA_W, INT_W+FRAC_W, packed operand/result width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  request strobe; sampled only when o_busy=0.
- i_data_a  input  DATA_W  dividend.
- i_data_b  input  DATA_W  divisor.
- o_busy  output  1  high from the cycle after acceptance through the OUT cycle.
- o_valid  output  1  one-cycle pulse marking o_data as a new result.
- o_data  output  DATA_W  quotient; held until the next result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (i_clk, i_rst).
- Reset (async, any state including mid-operation): state=IDLE, o_busy=0, o_valid=0, o_data=0, counter and datapath registers=0. Any in-flight operation is discarded.
- States: IDLE, CALC, ROUND, OUT.
- IDLE: if i_valid=1 in cycle T, capture the operands and go to CALC at T+1.
  - sign = a_sign ^ b_sign.
  - exp_tmp = a_exp - b_exp + 127, computed (INT_W+1)-bit signed.
  - Remainder R = {1'b0,1,a_frac} (FRAC_W+2 bits).
  - Divisor M = {1,b_frac}.
  - Quotient Q = 0; counter = 0.
- CALC: lasts FRAC_W+3 cycles (26 at default).
  - Each cycle: if R >= M then Q = {Q,1}, R = (R-M)<<1; else Q = {Q,0}, R = R<<1.
  - Counter increments; at count FRAC_W+2, go to ROUND.
- ROUND: single cycle.
  - Q[FRAC_W+2]=1: mantissa = Q[FRAC_W+2:2], round bit = Q[1], sticky = Q[0] | (R!=0), exponent = exp_tmp.
  - Else (Q[FRAC_W+1] is then guaranteed 1): mantissa = Q[FRAC_W+1:1], round bit = Q[0], sticky = (R!=0), exponent = exp_tmp-1.
  - Round to nearest even: increment when round=1 and (sticky=1 or mantissa LSB=1).
  - If the increment carries out of the mantissa MSB: fraction = 0, exponent += 1.
  - Result exponent = low INT_W-1 bits, modulo 2^(INT_W-1). No overflow/underflow saturation, no denormal handling, same as the multiplier.
- Special operands, decided at capture and applied in ROUND; latency is unchanged:
  - b exponent field == 0: result = {sign, all-ones exponent, 0 fraction}.
  - Else a exponent field == 0: result = {sign, 0, 0}.
  - NaN/Inf inputs are not recognised; they are processed arithmetically.
- OUT: o_data updated, o_valid=1 for exactly this cycle, return to IDLE.
- Latency: accept at T → o_valid at T+FRAC_W+5 (T+28 at default).
- i_valid while o_busy=1 is ignored, with no queuing.
- A new request can be accepted in the cycle after OUT.
- o_data is stable outside OUT updates.
- Operands do not need to be held after the acceptance cycle.

Test Plan:
- Reset in IDLE, then check idle outputs → o_busy=0, o_valid=0, o_data=0x00000000.
- a=0x40C00000 (6.0), b=0x40000000 (2.0), i_valid at T → o_valid at T+28, o_data=0x40400000 (3.0), o_busy low after OUT.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) → 0x3EAAAAAB, exercising the round-up path. Also a=0xC0F00000 (-7.5), b=0x40200000 (2.5) → 0xC0400000.
- a=0x3F800000, b=0x00000000 → 0x7F800000 at T+28. Also a=0x00000000, b=0x40000000 → 0x00000000.
- Assert i_valid with different operands at T+5 and T+20 of a busy operation → both ignored. Exactly one o_valid, carrying the first result.
- Assert i_rst at T+10 of an operation → o_busy=0 immediately, no o_valid pulse. The next request 1.0/2.0 (0x3F800000/0x40000000) → 0x3F000000.

Source files
------------

// File: rtl/fp_div.sv
// Sequential floating-point divider: restoring division, one quotient bit per cycle,
// then round-to-nearest-even. Same packed format and bias as the team's FP multiplier.
module fp_div #(
    parameter int INT_W  = 9,
    parameter int FRAC_W = 23,
    parameter int DATA_W = INT_W + FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam int EXP_W = INT_W - 1;
    localparam int Q_W   = FRAC_W + 3;
    localparam int R_W   = FRAC_W + 2;
    localparam int M_W   = FRAC_W + 1;
    localparam int CNT_W = $clog2(FRAC_W + 3);

    localparam logic [EXP_W-1:0] BIAS     = EXP_W'(127);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ROUND,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [R_W-1:0]      rem_q, rem_d;
    logic [M_W-1:0]      dvs_q, dvs_d;
    logic [Q_W-1:0]      quo_q, quo_d;
    // Only the low exponent bits reach the result, so the biased difference is kept modulo 2^EXP_W.
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic                sign_q, sign_d;
    logic                b_zero_q, b_zero_d;
    logic                a_zero_q, a_zero_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [EXP_W-1:0]    a_exp, b_exp;
    logic                norm;
    logic [FRAC_W-1:0]   frac_raw;
    logic                rnd_bit;
    logic                sticky;
    logic                round_up;
    logic [FRAC_W:0]     frac_sum;
    logic [EXP_W-1:0]    exp_res;
    logic [DATA_W-1:0]   result;

    assign a_exp = i_data_a[DATA_W-2 -: EXP_W];
    assign b_exp = i_data_b[DATA_W-2 -: EXP_W];

    // Normalisation and rounding of the finished quotient, consumed only in S_ROUND.
    always_comb begin
        norm     = quo_q[Q_W-1];
        frac_raw = norm ? quo_q[Q_W-2:2] : quo_q[Q_W-3:1];
        rnd_bit  = norm ? quo_q[1] : quo_q[0];
        sticky   = (norm & quo_q[0]) | (rem_q != '0);
        round_up = rnd_bit & (sticky | frac_raw[0]);
        // The hidden bit is always 1, so a carry out of the fraction is a carry out of the mantissa;
        // the low bits of frac_sum are then already zero.
        frac_sum = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};
        exp_res  = exp_q - {{(EXP_W-1){1'b0}}, ~norm} + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};

        if (b_zero_q) begin
            result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero_q) begin
            result = {sign_q, {(DATA_W-1){1'b0}}};
        end else begin
            result = {sign_q, exp_res, frac_sum[FRAC_W-1:0]};
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        b_zero_d = b_zero_q;
        a_zero_d = a_zero_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d  = S_CALC;
                    sign_d   = i_data_a[DATA_W-1] ^ i_data_b[DATA_W-1];
                    exp_d    = a_exp - b_exp + BIAS;
                    rem_d    = {1'b0, 1'b1, i_data_a[FRAC_W-1:0]};
                    dvs_d    = {1'b1, i_data_b[FRAC_W-1:0]};
                    quo_d    = '0;
                    cnt_d    = '0;
                    b_zero_d = (b_exp == '0);
                    a_zero_d = (a_exp == '0);
                end
            end
            S_CALC: begin
                // R stays below 2M, so the shifted partial remainder never loses its top bit.
                if (rem_q >= {1'b0, dvs_q}) begin
                    quo_d = {quo_q[Q_W-2:0], 1'b1};
                    rem_d = (rem_q - {1'b0, dvs_q}) << 1;
                end else begin
                    quo_d = {quo_q[Q_W-2:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                data_d  = result;
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: datapath registers are cleared too, so a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            b_zero_q <= 1'b0;
            a_zero_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            b_zero_q <= b_zero_d;
            a_zero_q <= a_zero_d;
            data_q   <= data_d;
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign o_valid = (state_q == S_OUT);
    assign o_data  = data_q;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed cases plus random operands checked against an
// integer-division reference model; a monitor pops expectations on every o_valid.
module tb_fp_div;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    fp_div dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .i_data_a(i_data_a),
        .i_data_b(i_data_b),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact quotient of the 24-bit mantissas via 64-bit integer division,
    // then nearest-even rounding on the truncated bits plus remainder.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic              sign;
        int                ea, eb, e;
        longint unsigned   am, bm, q, r, mant;
        logic              rnd, sticky;
        logic [7:0]        e8;
        sign = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        if (eb == 0) return {sign, 8'hFF, 23'd0};
        if (ea == 0) return {sign, 31'd0};
        am = 64'(a[22:0]) | (64'd1 << 23);
        bm = 64'(b[22:0]) | (64'd1 << 23);
        q  = (am << 39) / bm;
        r  = (am << 39) % bm;
        e  = ea - eb + 127;
        if (q >= (64'd1 << 39)) begin
            mant   = q >> 16;
            rnd    = q[15];
            sticky = ((q & 64'h7FFF) != 0) || (r != 0);
        end else begin
            e      = e - 1;
            mant   = q >> 15;
            rnd    = q[14];
            sticky = ((q & 64'h3FFF) != 0) || (r != 0);
        end
        if (rnd && (sticky || mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        e8 = e[7:0];
        return {sign, e8, mant[22:0]};
    endfunction

    // Monitor: every o_valid must match the oldest expectation, on the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got %08h expected no result (cycle %0d)", o_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", o_data, e.data);
                    check("latency", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one request at a negedge; optionally register the expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] exp, output int t0);
        exp_t e;
        @(negedge clk);
        check("idle_before_issue", o_busy, 1'b0);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        t0       = cyc;
        if (push) begin
            e.data = exp;
            e.due  = cyc + 28;
            sb.push_back(e);
        end
        @(negedge clk);
        i_valid  = 1'b0;
        i_data_a = $urandom;
        i_data_b = $urandom;
        check("busy_after_accept", o_busy, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", o_busy, 1'b0);
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int t0;
        issue(a, b, 1'b1, exp, t0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("data_held", o_data, exp);
    endtask

    initial begin
        int t0;
        logic [31:0] a, b;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", o_busy, 1'b0);
        check("reset_valid", o_valid, 1'b0);
        check("reset_data", o_data, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", o_busy, 1'b0);
        check("idle_valid", o_valid, 1'b0);
        check("idle_data", o_data, 32'h0);

        directed(32'h40C00000, 32'h40000000, 32'h40400000);
        directed(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
        directed(32'hC0F00000, 32'h40200000, 32'hC0400000);
        directed(32'h3F800000, 32'h00000000, 32'h7F800000);
        directed(32'h00000000, 32'h40000000, 32'h00000000);

        // Requests during a busy operation must be dropped.
        issue(32'h41200000, 32'h40800000, 1'b1, 32'h40200000, t0);
        goto_cycle(t0 + 5);
        i_valid = 1'b1; i_data_a = 32'h3F800000; i_data_b = 32'h40400000;
        @(negedge clk);
        i_valid = 1'b0;
        check("busy_ignore1", o_busy, 1'b1);
        goto_cycle(t0 + 20);
        i_valid = 1'b1; i_data_a = 32'h42000000; i_data_b = 32'h3F000000;
        @(negedge clk);
        i_valid = 1'b0;
        check("busy_ignore2", o_busy, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignore_data", o_data, 32'h40200000);

        // Reset mid-operation: no result may ever appear for the aborted request.
        issue(32'h40C00000, 32'h40000000, 1'b0, 32'h0, t0);
        goto_cycle(t0 + 10);
        rst = 1'b1;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_valid", o_valid, 1'b0);
        check("abort_data", o_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        directed(32'h3F800000, 32'h40000000, 32'h3F000000);

        // Random operands, occasional zero exponents, back-to-back where possible.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            a[30:23] = 8'($urandom_range(1, 254));
            b[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 9) == 0) a[30:23] = 8'h00;
            if ($urandom_range(0, 9) == 0) b[30:23] = 8'h00;
            issue(a, b, 1'b1, ref_div(a, b), t0);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
